// File: rtl/sram_sync_arbiter.sv
// rtl/sram_sync_arbiter.sv - round-robin arbiter sharing one sram_sync_ctrl among NUM_REQ requesters
// Enforces a minimum command gap, caps reads in flight and routes in-order read responses.
module sram_sync_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int BE_W      = (DATA_W / 8 > 0) ? DATA_W / 8 : 1,
  parameter int MAX_OUTST = 4,
  parameter int GAP_CYC   = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         m_req,
  input  logic [NUM_REQ-1:0]         m_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  m_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  m_wdata,
  input  logic [NUM_REQ*BE_W-1:0]    m_be,
  output logic [NUM_REQ-1:0]         m_gnt,
  output logic [NUM_REQ-1:0]         m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       s_req,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [BE_W-1:0]            s_be,
  input  logic [DATA_W-1:0]          s_rdata,
  input  logic                       s_rvalid,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic                       err_orphan
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW  = $clog2(MAX_OUTST) + 1;

  typedef enum logic {IDLE, GAP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         gap_cnt;
  logic [IDW-1:0]     rr_ptr, win;
  logic               win_vld, grant, push, pop, slot_free;
  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     id_fifo [MAX_OUTST];
  logic [PW-1:0]      wr_ptr, rd_ptr;

  // A pop only frees a slot from the next cycle on, so eligibility uses the registered count.
  assign slot_free = (outst_cnt < CW'(MAX_OUTST));
  assign elig      = m_req & (m_we | {NUM_REQ{slot_free}});
  assign grant     = rstn && (state == IDLE) && win_vld;
  assign push      = grant && !m_we[win];
  assign pop       = s_rvalid && (outst_cnt != '0);
  assign m_rdata   = s_rdata;

  always_comb begin : rr_search
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && elig[IDW'(idx)]) begin
        win_vld = 1'b1;
        win     = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant && GAP_CYC > 0) state_nxt = GAP;
      GAP:     if (gap_cnt <= 4'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    if (grant) m_gnt[win] = 1'b1;
    if (pop)   m_rvalid[id_fifo[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt    <= '0;
      rr_ptr     <= '0;
      s_req      <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_be       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      outst_cnt  <= '0;
      err_orphan <= 1'b0;
    end else begin
      s_req <= grant;
      if (grant)               gap_cnt <= 4'(GAP_CYC);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - 4'd1;
      if (grant) begin
        rr_ptr  <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        s_we    <= m_we[win];
        s_addr  <= m_addr[win*ADDR_W +: ADDR_W];
        s_wdata <= m_wdata[win*DATA_W +: DATA_W];
        s_be    <= m_be[win*BE_W +: BE_W];
      end
      if (push) wr_ptr <= (wr_ptr == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: ;
      endcase
      if (s_rvalid && outst_cnt == '0) err_orphan <= 1'b1;
    end
  end

  // ID storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= win;
  end

endmodule
